config_register_programmer: RTL and testbench

Serial master that drives the SELDYN/SELSTAT/SDI/SDO chain of the dynamic (16-bit) and static (88-bit) configuration shift registers. It takes a parallel configuration word and a target select, shifts the word into the selected register MSB-first, and captures the previous register contents from the chain output as readback. An optional verify pass re-shifts the same word and checks that the register content returned matches. It sits in the digital core between the control/host interface and the configuration register. It never drives the register's PLOAD, which is tied low at integration.

---
 rtl/config_register_programmer.sv | 189 ++++++++++++++++++
 tb/tb_config_register_programmer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/config_register_programmer.sv
// config_register_programmer
//
// Serial master for the SELDYN/SELSTAT/SDO/SDI chain of the dynamic (16-bit)
// and static (88-bit) configuration shift registers. A parallel word is
// shifted MSB-first into the selected register. The old register contents
// return on SDI and are captured as readback. An optional second pass
// re-shifts the same word and compares what comes back against it.
//
// Ports
//   CLK      system clock, shared with the configuration register
//   RST_N    asynchronous active-low reset
//   START    single-cycle request, accepted only in IDLE
//   TARGET   0 = dynamic register, 1 = static register (sampled with START)
//   VERIFY   1 = run a verify pass (sampled with START)
//   WDATA    word to write; the dynamic register uses the low SIZESRDYN bits
//   SELDYN   shift enable to the dynamic register
//   SELSTAT  shift enable to the static register
//   SDO      serial data to the register's SDI
//   SDI      serial data from the register's SDO (its current MSB)
//   BUSY     high in SHIFT1, GAP and SHIFT2
//   DONE     one-cycle completion pulse
//   RDATA    register contents captured in pass 1 (upper bits zero for dynamic)
//   ERR      verify mismatch flag
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for START
// ST_SHIFT1 | write pass; old contents are captured into RDATA
// ST_GAP    | one idle cycle between passes; the transmit word is reloaded
// ST_SHIFT2 | verify pass; the returned word is compared against WDATA
// ST_DONE   | one-cycle DONE pulse
module config_register_programmer #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16,
  parameter int CNTW       = 7
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  TARGET,
  input  logic                  VERIFY,
  input  logic [SIZESRSTAT-1:0] WDATA,
  output logic                  SELDYN,
  output logic                  SELSTAT,
  output logic                  SDO,
  input  logic                  SDI,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [SIZESRSTAT-1:0] RDATA,
  output logic                  ERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT1,
    ST_GAP,
    ST_SHIFT2,
    ST_DONE
  } state_t;

  localparam logic [CNTW-1:0] LAST_DYN  = CNTW'(SIZESRDYN - 1);
  localparam logic [CNTW-1:0] LAST_STAT = CNTW'(SIZESRSTAT - 1);
  localparam logic [SIZESRSTAT-1:0] DYN_MASK =
    {SIZESRSTAT{1'b1}} >> (SIZESRSTAT - SIZESRDYN);

  state_t                  state, state_nxt;
  logic                    target_q, verify_q;
  logic [SIZESRSTAT-1:0]   wdata_q;
  logic [SIZESRSTAT-1:0]   tx_sh;
  logic [SIZESRSTAT-1:0]   rx_sh;
  logic [CNTW-1:0]         cnt;

  logic                    accept;
  logic                    shifting;
  logic                    last;
  logic                    tgt_nxt;
  logic [SIZESRSTAT-1:0]   aligned_in;
  logic [SIZESRSTAT-1:0]   aligned_q;
  logic [SIZESRSTAT-1:0]   rx_nxt;
  logic [SIZESRSTAT-1:0]   exp_word;

  // The transmit shifter always sends from its top bit. A dynamic word is
  // therefore left-justified so that its bit N-1 sits at the shifter MSB.
  always_comb begin
    aligned_in = TARGET   ? WDATA   : (WDATA   << (SIZESRSTAT - SIZESRDYN));
    aligned_q  = target_q ? wdata_q : (wdata_q << (SIZESRSTAT - SIZESRDYN));
    exp_word   = target_q ? wdata_q : (wdata_q & DYN_MASK);
    rx_nxt     = {rx_sh[SIZESRSTAT-2:0], SDI};
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shifting  = 1'b0;
    last      = 1'b0;
    tgt_nxt   = target_q;
    case (state)
      ST_IDLE: begin
        if (START) begin
          accept    = 1'b1;
          tgt_nxt   = TARGET;
          state_nxt = ST_SHIFT1;
        end
      end
      ST_SHIFT1: begin
        shifting = 1'b1;
        last     = (cnt == (target_q ? LAST_STAT : LAST_DYN));
        if (last) state_nxt = verify_q ? ST_GAP : ST_DONE;
      end
      ST_GAP: begin
        state_nxt = ST_SHIFT2;
      end
      ST_SHIFT2: begin
        shifting = 1'b1;
        last     = (cnt == (target_q ? LAST_STAT : LAST_DYN));
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      target_q <= 1'b0;
      verify_q <= 1'b0;
      wdata_q  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cnt      <= '0;
      SDO      <= 1'b0;
      RDATA    <= '0;
      ERR      <= 1'b0;
    end else if (accept) begin
      target_q <= TARGET;
      verify_q <= VERIFY;
      wdata_q  <= WDATA;
      // The first bit goes out in the very next cycle, so it moves straight
      // into SDO and the shifter keeps only the remaining bits.
      SDO      <= aligned_in[SIZESRSTAT-1];
      tx_sh    <= aligned_in << 1;
      rx_sh    <= '0;
      cnt      <= '0;
      ERR      <= 1'b0;
    end else if (state == ST_GAP) begin
      SDO      <= aligned_q[SIZESRSTAT-1];
      tx_sh    <= aligned_q << 1;
      rx_sh    <= '0;
      cnt      <= '0;
    end else if (shifting) begin
      rx_sh <= rx_nxt;
      cnt   <= cnt + CNTW'(1);
      if (last) begin
        SDO <= 1'b0;
        if (state == ST_SHIFT1) RDATA <= rx_nxt;
        else                    ERR   <= (rx_nxt != exp_word);
      end else begin
        SDO   <= tx_sh[SIZESRSTAT-1];
        tx_sh <= tx_sh << 1;
      end
    end
  end

  // Outputs are registered from the next state so that they line up with it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SELDYN  <= 1'b0;
      SELSTAT <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      SELDYN  <= ((state_nxt == ST_SHIFT1) || (state_nxt == ST_SHIFT2)) && !tgt_nxt;
      SELSTAT <= ((state_nxt == ST_SHIFT1) || (state_nxt == ST_SHIFT2)) &&  tgt_nxt;
      BUSY    <= (state_nxt == ST_SHIFT1) || (state_nxt == ST_GAP) ||
                 (state_nxt == ST_SHIFT2);
      DONE    <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_config_register_programmer.sv
module tb_config_register_programmer;

  localparam logic [87:0] SDEF = 88'h5A0F_0F00_00FF_FF12_34AB_CD;
  localparam logic [87:0] W88  = 88'h00A5_5A5A_5A5A_5A5A_5A5A_5A;
  localparam logic [87:0] W4   = 88'hFEDC_BA98_7654_3210_0123_45;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        TARGET = 1'b0;
  logic        VERIFY = 1'b0;
  logic [87:0] WDATA = '0;
  logic        SELDYN, SELSTAT, SDO, SDI, BUSY, DONE, ERR;
  logic [87:0] RDATA;

  // External configuration register: shifts SDO in while selected and
  // presents its MSB combinationally on the selected chain.
  logic [15:0] dyn_reg;
  logic [87:0] stat_reg;
  logic        stuck = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  config_register_programmer dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .TARGET(TARGET), .VERIFY(VERIFY),
    .WDATA(WDATA), .SELDYN(SELDYN), .SELSTAT(SELSTAT), .SDO(SDO), .SDI(SDI),
    .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .ERR(ERR)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dyn_reg  <= 16'h4000;
      stat_reg <= SDEF;
    end else begin
      if (SELDYN)  dyn_reg  <= {dyn_reg[14:0], SDO};
      if (SELSTAT) stat_reg <= {stat_reg[86:0], SDO};
    end
  end

  assign SDI = stuck   ? 1'b0 :
               SELDYN  ? dyn_reg[15] :
               SELSTAT ? stat_reg[87] : 1'b0;

  typedef struct {
    logic        target;
    logic        verify;
    logic [87:0] wdata;
    logic [87:0] exp_rdata;
    logic        exp_err;
    int          exp_done;
    int          exp_sel;
    int          exp_gap;
    logic [87:0] exp_reg;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pulse_start();
    START  = 1'b1;
    TARGET = 1'b1;
    VERIFY = 1'b0;
    WDATA  = '1;
  endtask

  // inject: bit0 = START pulse in SHIFT1, bit1 = in GAP, bit2 = in DONE cycle
  task automatic run_xfer(input logic tgt, input logic ver, input logic [87:0] wd,
                          input logic stuck2, input logic [2:0] inject,
                          output int done_at, output int sel_cyc, output int gap_cyc,
                          output logic excl_ok, output logic err_at_1);
    done_at  = -1;
    sel_cyc  = 0;
    gap_cyc  = 0;
    excl_ok  = 1'b1;
    err_at_1 = 1'b1;
    @(negedge CLK);
    START  = 1'b1;
    TARGET = tgt;
    VERIFY = ver;
    WDATA  = wd;
    for (int c = 1; c <= 400; c++) begin
      @(negedge CLK);
      START  = 1'b0;
      TARGET = 1'b0;
      VERIFY = 1'b0;
      WDATA  = '0;
      if (c == 1) err_at_1 = ERR;
      if (SELDYN && SELSTAT) excl_ok = 1'b0;
      if (!SELDYN && !SELSTAT && SDO) excl_ok = 1'b0;
      if (SELDYN || SELSTAT) sel_cyc++;
      if (c == 3 && inject[0]) pulse_start();
      if (BUSY && !SELDYN && !SELSTAT) begin
        gap_cyc++;
        if (stuck2) stuck = 1'b1;
        if (inject[1]) pulse_start();
      end
      if (DONE) begin
        stuck   = 1'b0;
        done_at = c - 1;
        if (inject[2]) begin
          pulse_start();
          @(posedge CLK);
          #1;
          START  = 1'b0;
          TARGET = 1'b0;
          WDATA  = '0;
        end
        break;
      end
    end
    if (done_at < 0) begin
      $display("FAIL done_timeout: no DONE within 400 cycles");
      n_total++;
    end
  endtask

  int   d_at, s_cyc, g_cyc;
  logic ex_ok, e1;

  initial begin
    vecs[0] = '{1'b0, 1'b0, {72'h123456789ABCDEF012, 16'hA5C3}, 88'h4000, 1'b0, 16, 16, 0, 88'hA5C3};
    vecs[1] = '{1'b1, 1'b1, W88, SDEF, 1'b0, 177, 176, 1, W88};
    vecs[2] = '{1'b0, 1'b1, {72'h0, 16'h1234}, 88'hA5C3, 1'b0, 33, 32, 1, 88'h1234};
    vecs[3] = '{1'b1, 1'b0, W4, W88, 1'b0, 88, 88, 0, W4};
    vecs[4] = '{1'b0, 1'b0, {72'h0F0F0F0F0F0F0F0F0F, 16'hFFFF}, 88'h1234, 1'b0, 16, 16, 0, 88'hFFFF};

    #1;
    check("rst_seldyn",  88'(SELDYN),  88'h0);
    check("rst_selstat", 88'(SELSTAT), 88'h0);
    check("rst_sdo",     88'(SDO),     88'h0);
    check("rst_busy",    88'(BUSY),    88'h0);
    check("rst_done",    88'(DONE),    88'h0);
    check("rst_rdata",   RDATA,        88'h0);
    check("rst_err",     88'(ERR),     88'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].target, vecs[i].verify, vecs[i].wdata, 1'b0, 3'b000,
               d_at, s_cyc, g_cyc, ex_ok, e1);
      check($sformatf("v%0d_rdata", i), RDATA, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 88'(ERR), 88'(vecs[i].exp_err));
      check($sformatf("v%0d_done_at", i), 88'(d_at), 88'(vecs[i].exp_done));
      check($sformatf("v%0d_sel_cycles", i), 88'(s_cyc), 88'(vecs[i].exp_sel));
      check($sformatf("v%0d_gap_cycles", i), 88'(g_cyc), 88'(vecs[i].exp_gap));
      check($sformatf("v%0d_reg", i), vecs[i].target ? stat_reg : {72'h0, dyn_reg},
            vecs[i].exp_reg);
      check($sformatf("v%0d_excl", i), 88'(ex_ok), 88'h1);
    end

    // Verify failure: SDI stuck low during the second pass.
    run_xfer(1'b0, 1'b1, {72'h0, 16'hFFFF}, 1'b1, 3'b000, d_at, s_cyc, g_cyc, ex_ok, e1);
    check("vf_rdata",   RDATA,    88'hFFFF);
    check("vf_err",     88'(ERR), 88'h1);
    check("vf_done_at", 88'(d_at), 88'd33);
    check("vf_excl",    88'(ex_ok), 88'h1);
    run_xfer(1'b0, 1'b0, {72'h0, 16'h0F0F}, 1'b0, 3'b000, d_at, s_cyc, g_cyc, ex_ok, e1);
    check("vf_err_clear_at_accept", 88'(e1), 88'h0);
    check("vf_err_after",  88'(ERR), 88'h0);
    check("vf_next_rdata", RDATA, 88'hFFFF);

    // Busy rejection: STARTs in SHIFT1, GAP and DONE are all ignored.
    run_xfer(1'b0, 1'b1, {72'h0, 16'h5A5A}, 1'b0, 3'b111, d_at, s_cyc, g_cyc, ex_ok, e1);
    check("busy_done_at", 88'(d_at), 88'd33);
    check("busy_sel",     88'(s_cyc), 88'd32);
    check("busy_gap",     88'(g_cyc), 88'd1);
    check("busy_rdata",   RDATA, 88'h0F0F);
    check("busy_reg",     {72'h0, dyn_reg}, 88'h5A5A);
    check("busy_stat_untouched", stat_reg, W4);
    check("busy_excl",    88'(ex_ok), 88'h1);
    run_xfer(1'b0, 1'b0, {72'h0, 16'h3C3C}, 1'b0, 3'b000, d_at, s_cyc, g_cyc, ex_ok, e1);
    check("after_done_rdata",   RDATA, 88'h5A5A);
    check("after_done_done_at", 88'(d_at), 88'd16);

    // Reset in the middle of a static SHIFT1.
    @(negedge CLK);
    START  = 1'b1;
    TARGET = 1'b1;
    WDATA  = W88;
    @(negedge CLK);
    START  = 1'b0;
    TARGET = 1'b0;
    repeat (5) @(negedge CLK);
    check("mid_selstat_before", 88'(SELSTAT), 88'h1);
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_rst_seldyn",  88'(SELDYN),  88'h0);
    check("mid_rst_selstat", 88'(SELSTAT), 88'h0);
    check("mid_rst_sdo",     88'(SDO),     88'h0);
    check("mid_rst_busy",    88'(BUSY),    88'h0);
    check("mid_rst_done",    88'(DONE),    88'h0);
    check("mid_rst_rdata",   RDATA,        88'h0);
    check("mid_rst_err",     88'(ERR),     88'h0);
    check("mid_rst_dyn_reg", {72'h0, dyn_reg}, 88'h4000);
    check("mid_rst_stat_reg", stat_reg, SDEF);
    @(negedge CLK);
    RST_N = 1'b1;
    run_xfer(1'b0, 1'b0, {72'h0, 16'h0001}, 1'b0, 3'b000, d_at, s_cyc, g_cyc, ex_ok, e1);
    check("post_rst_rdata",   RDATA, 88'h4000);
    check("post_rst_done_at", 88'(d_at), 88'd16);
    check("post_rst_reg",     {72'h0, dyn_reg}, 88'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
